// File: rtl/mem_stage.sv
// Memory-access stage: latches the execute bus, extracts/extends load data, feeds writeback.
// Latency: one register stage; SRAM read data arrives in the first MS cycle and is held across stalls.
// Backpressure: ms_allowin drops while a valid instruction waits on ws_allowin; flushes clear ms_valid.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 170,
  parameter int MS_TO_WS_BUS_WD = 160,
  parameter int MS_FWD_WD       = 41
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       final_ex,
  input  logic                       back_ertn_flush,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic [31:0]                data_sram_rdata,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_FWD_WD-1:0]       ms_forward,
  output logic                       ms_ertn_flush,
  output logic                       ms_ex
);

  logic                       ms_valid;
  logic                       ms_ready_go;
  logic [ES_TO_MS_BUS_WD-1:0] bus_r;
  logic                       first;
  logic [31:0]                hold_reg;
  logic                       accept;

  // Decoded fields of the latched execute bus
  logic        ertn;
  logic        ex;
  logic        csr_re;
  logic [1:0]  addr_lo;
  logic        ld_w, ld_b, ld_bu, ld_h, ld_hu;
  logic        st_b, st_h;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] result;
  logic        unused_bits;

  logic [31:0] rdata;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_value;
  logic [31:0] final_result;

  assign ertn         = bus_r[168];
  assign ex           = bus_r[160];
  assign csr_re       = bus_r[159];
  assign addr_lo      = bus_r[79:78];
  assign ld_w         = bus_r[77];
  assign ld_b         = bus_r[76];
  assign ld_bu        = bus_r[75];
  assign ld_h         = bus_r[74];
  assign ld_hu        = bus_r[73];
  assign st_b         = bus_r[72];
  assign st_h         = bus_r[71];
  assign res_from_mem = bus_r[70];
  assign gr_we        = bus_r[69];
  assign dest         = bus_r[68:64];
  assign result       = bus_r[63:32];

  // Store flags only matter to execute's SRAM request; they stop here.
  assign unused_bits = st_b ^ st_h;

  // Handshake: memory access never stalls this stage on its own.
  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !ms_valid | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid & ms_ready_go & ~final_ex;
  assign accept         = es_to_ms_valid & ms_allowin;

  // Valid bit: commit-time flushes win over a new accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (final_ex | back_ertn_flush) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  // Bus register captures a new instruction whenever one is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_r <= '0;
    end else if (accept) begin
      bus_r <= es_to_ms_bus;
    end
  end

  // First-cycle flag marks the one cycle where SRAM data is live on the port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first <= 1'b0;
    end else begin
      first <= accept;
    end
  end

  // Hold register keeps the first-cycle read data for the rest of a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_reg <= '0;
    end else if (first) begin
      hold_reg <= data_sram_rdata;
    end
  end

  assign rdata = first ? data_sram_rdata : hold_reg;

  // Byte and halfword lane selection from the low address bits.
  always_comb begin
    load_byte = rdata[7:0];
    case (addr_lo)
      2'd0: load_byte = rdata[7:0];
      2'd1: load_byte = rdata[15:8];
      2'd2: load_byte = rdata[23:16];
      2'd3: load_byte = rdata[31:24];
      default: load_byte = rdata[7:0];
    endcase
    load_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Sign/zero extension according to the load type.
  always_comb begin
    load_value = rdata;
    if (ld_b) begin
      load_value = {{24{load_byte[7]}}, load_byte};
    end else if (ld_bu) begin
      load_value = {24'd0, load_byte};
    end else if (ld_h) begin
      load_value = {{16{load_half[15]}}, load_half};
    end else if (ld_hu) begin
      load_value = {16'd0, load_half};
    end else if (ld_w) begin
      load_value = rdata;
    end
  end

  assign final_result = res_from_mem ? load_value : result;

  // Writeback bus drops addr_lo, load and store type flags.
  assign ms_to_ws_bus = {bus_r[169:80], gr_we, dest, final_result, bus_r[31:0]};

  // Forwarding/hazard info for decode, all fields qualified by ms_valid.
  assign ms_forward = {ms_valid & csr_re,
                       ms_valid & (ex | ertn),
                       final_result & {32{ms_valid}},
                       dest & {5{ms_valid}},
                       ms_valid & gr_we,
                       ms_valid};

  assign ms_ertn_flush = ms_valid & ertn;
  assign ms_ex         = ms_valid & ex;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         final_ex = 1'b0;
  logic         back_ertn_flush = 1'b0;
  logic         ws_allowin = 1'b1;
  logic         ms_allowin;
  logic         es_to_ms_valid = 1'b0;
  logic [169:0] es_to_ms_bus = '0;
  logic [31:0]  data_sram_rdata = '0;
  logic         ms_to_ws_valid;
  logic [159:0] ms_to_ws_bus;
  logic [40:0]  ms_forward;
  logic         ms_ertn_flush;
  logic         ms_ex;

  int n_chk = 0;
  int n_fail = 0;

  mem_stage dut (
    .clk(clk), .reset(reset), .final_ex(final_ex), .back_ertn_flush(back_ertn_flush),
    .ws_allowin(ws_allowin), .ms_allowin(ms_allowin), .es_to_ms_valid(es_to_ms_valid),
    .es_to_ms_bus(es_to_ms_bus), .data_sram_rdata(data_sram_rdata),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus), .ms_forward(ms_forward),
    .ms_ertn_flush(ms_ertn_flush), .ms_ex(ms_ex)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [169:0] act, input logic [169:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Load result from a whole word: shift to the addressed lane, then extend.
  function automatic logic [31:0] ext(input int kind, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (kind)
      1: return w;
      2: return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
      3: return b;
      4: return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      5: return h;
      default: return w;
    endcase
  endfunction

  function automatic int kind_of(input logic [169:0] bus);
    if (bus[77]) return 1;
    if (bus[76]) return 2;
    if (bus[75]) return 3;
    if (bus[74]) return 4;
    if (bus[73]) return 5;
    return 0;
  endfunction

  // kind: 0 alu, 1 ld.w, 2 ld.b, 3 ld.bu, 4 ld.h, 5 ld.hu, 6 st.b, 7 st.h
  function automatic logic [169:0] mk(input int kind, input logic [1:0] a, input logic [31:0] res,
                                      input logic [4:0] dst, input logic we);
    logic [169:0] b;
    b = '0;
    b[79:78] = a;
    if (kind >= 1 && kind <= 5) begin
      b[78 - kind] = 1'b1;
      b[70] = 1'b1;
    end
    if (kind == 6) b[72] = 1'b1;
    if (kind == 7) b[71] = 1'b1;
    b[69] = we;
    b[68:64] = dst;
    b[63:32] = res;
    b[31:0] = 32'h1c00_0000 + {24'd0, a, 6'd0};
    return b;
  endfunction

  // Behavioural model: instruction in the stage and the word it loaded.
  logic         m_valid = 1'b0;
  logic [169:0] m_inst = '0;
  logic         m_known = 1'b1;
  logic [31:0]  m_word = '0;

  always @(posedge clk or posedge reset) begin
    logic allow;
    if (reset) begin
      m_valid = 1'b0;
      m_inst  = '0;
      m_known = 1'b1;
      m_word  = '0;
    end else begin
      allow = !m_valid || ws_allowin;
      if (es_to_ms_valid && allow) begin
        m_inst  = es_to_ms_bus;
        m_known = 1'b0;
      end else if (!m_known) begin
        m_known = 1'b1;
        m_word  = data_sram_rdata;
      end
      if (final_ex || back_ertn_flush) m_valid = 1'b0;
      else if (allow) m_valid = es_to_ms_valid;
    end
  end

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    logic [31:0] w, fr;
    logic [159:0] eb;
    logic [40:0]  ef;
    w  = m_known ? m_word : data_sram_rdata;
    fr = m_inst[70] ? ext(kind_of(m_inst), m_inst[79:78], w) : m_inst[63:32];
    eb = {m_inst[169:80], m_inst[69], m_inst[68:64], fr, m_inst[31:0]};
    ef = m_valid ? {m_inst[159], m_inst[160] | m_inst[168], fr, m_inst[68:64], m_inst[69], 1'b1} : 41'd0;
    chk("ms_allowin", {169'd0, ms_allowin}, {169'd0, !m_valid || ws_allowin});
    chk("ms_to_ws_valid", {169'd0, ms_to_ws_valid}, {169'd0, m_valid && !final_ex});
    chk("ms_forward", {129'd0, ms_forward}, {129'd0, ef});
    chk("ms_ex", {169'd0, ms_ex}, {169'd0, m_valid && m_inst[160]});
    chk("ms_ertn_flush", {169'd0, ms_ertn_flush}, {169'd0, m_valid && m_inst[168]});
    if (m_valid) chk("ms_to_ws_bus", {10'd0, ms_to_ws_bus}, {10'd0, eb});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_test(input int kind, input logic [1:0] a, input logic [31:0] rd, input logic [31:0] exp);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(kind, a, 32'h5555_AAAA, 5'd7, 1'b1);
    ws_allowin     = 1'b1;
    cyc();
    es_to_ms_valid  = 1'b0;
    data_sram_rdata = rd;
    @(negedge clk);
    chk("load_result", {138'd0, ms_to_ws_bus[63:32]}, {138'd0, exp});
    chk("load_valid", {169'd0, ms_to_ws_valid}, 170'd1);
    cyc();
  endtask

  initial begin
    // Model pins with hand-computed values
    chk("model_ldb", {138'd0, ext(2, 2'd3, 32'h80123456)}, {138'd0, 32'hFFFFFF80});
    chk("model_ldhu", {138'd0, ext(5, 2'd2, 32'h80011234)}, {138'd0, 32'h00008001});
    chk("model_ldh", {138'd0, ext(4, 2'd2, 32'h80011234)}, {138'd0, 32'hFFFF8001});
    chk("model_ldbu", {138'd0, ext(3, 2'd1, 32'h80011234)}, {138'd0, 32'h00000012});

    // Reset state
    #2;
    chk("rst_bus", {10'd0, ms_to_ws_bus}, 170'd0);
    chk("rst_fwd", {129'd0, ms_forward}, 170'd0);
    chk("rst_valid", {169'd0, ms_to_ws_valid}, 170'd0);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();

    // Load extraction
    load_test(2, 2'd3, 32'h80123456, 32'hFFFFFF80);
    load_test(5, 2'd2, 32'h80011234, 32'h00008001);
    load_test(4, 2'd2, 32'h80011234, 32'hFFFF8001);
    load_test(3, 2'd1, 32'h80011234, 32'h00000012);

    // ld.w under a writeback stall with changing SRAM data
    ws_allowin = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1, 2'd0, 32'h0, 5'd3, 1'b1);
    cyc();
    es_to_ms_valid = 1'b0;
    data_sram_rdata = 32'h11223344;
    @(negedge clk);
    chk("stall_allowin", {169'd0, ms_allowin}, 170'd0);
    cyc();
    data_sram_rdata = 32'hDEADBEEF;
    cyc();
    cyc();
    @(negedge clk);
    chk("stall_hold", {138'd0, ms_to_ws_bus[63:32]}, {138'd0, 32'h11223344});
    ws_allowin = 1'b1;
    cyc();

    // Exception then exception flush
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(0, 2'd0, 32'h0, 5'd0, 1'b0);
    es_to_ms_bus[160] = 1'b1;
    es_to_ms_bus[166:161] = 6'h09;
    ws_allowin = 1'b0;
    cyc();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    chk("ex_ms_ex", {169'd0, ms_ex}, 170'd1);
    chk("ex_fwd39", {169'd0, ms_forward[39]}, 170'd1);
    cyc();
    final_ex = 1'b1;
    #1;
    chk("ex_flush_valid", {169'd0, ms_to_ws_valid}, 170'd0);
    cyc();
    final_ex = 1'b0;
    ws_allowin = 1'b1;
    #1;
    chk("ex_cleared", {169'd0, ms_forward[0]}, 170'd0);

    // ALU result forwarding, then ertn and its flush
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(0, 2'd0, 32'h1234, 5'd5, 1'b1);
    cyc();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    chk("alu_fwd", {129'd0, ms_forward}, {129'd0, 1'b0, 1'b0, 32'h1234, 5'd5, 1'b1, 1'b1});
    cyc();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(0, 2'd0, 32'h0, 5'd0, 1'b0);
    es_to_ms_bus[168] = 1'b1;
    ws_allowin = 1'b0;
    cyc();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    chk("ertn_flag", {169'd0, ms_ertn_flush}, 170'd1);
    cyc();
    back_ertn_flush = 1'b1;
    cyc();
    back_ertn_flush = 1'b0;
    ws_allowin = 1'b1;
    #1;
    chk("ertn_cleared", {169'd0, ms_forward[0]}, 170'd0);

    // Asynchronous reset in the middle of a stall
    ws_allowin = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1, 2'd0, 32'h0, 5'd9, 1'b1);
    data_sram_rdata = 32'hCAFEF00D;
    cyc();
    es_to_ms_valid = 1'b0;
    cyc();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", {169'd0, ms_to_ws_valid}, 170'd0);
    chk("arst_fwd", {129'd0, ms_forward}, 170'd0);
    cyc();
    reset = 1'b0;
    ws_allowin = 1'b1;
    load_test(2, 2'd0, 32'h000000F0, 32'hFFFFFFF0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [95:0] r;
      int k;
      r = {$urandom, $urandom, $urandom};
      k = $urandom_range(0, 7);
      es_to_ms_valid = ($urandom_range(0, 9) < 7);
      ws_allowin = ($urandom_range(0, 9) < 7);
      final_ex = ($urandom_range(0, 19) == 0);
      back_ertn_flush = ($urandom_range(0, 19) == 0);
      data_sram_rdata = $urandom;
      es_to_ms_bus = mk(k, 2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      es_to_ms_bus[169:80] = r[89:0];
      es_to_ms_bus[160] = ($urandom_range(0, 9) == 0);
      es_to_ms_bus[168] = ($urandom_range(0, 9) == 0);
      es_to_ms_bus[31:0] = $urandom;
      cyc();
    end
    final_ex = 1'b0;
    back_ertn_flush = 1'b0;
    es_to_ms_valid = 1'b0;
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
